// File: rtl/rdma_slice_chain_dcpl_pkg.sv
// Shared constants and helpers for the RDMA register-slice chain.
package lynxTypes;

  localparam int SLICE_MODE_FULL  = 0;
  localparam int SLICE_MODE_LIGHT = 1;

  // Occupancy counter width: enough for 2*N beats, never narrower than 1 bit.
  function automatic int occ_bits(input int n_stages);
    if (n_stages == 0) return 1;
    return $clog2(2 * n_stages + 1);
  endfunction

endpackage

// File: rtl/rdma_slice_chain_dcpl_stage.sv
// One AXI4S register-slice stage: FULL (main + skid, registered ready) or
// LIGHT (single register, ready passes through combinationally).
module rdma_slice_stage
  import lynxTypes::*;
#(
  parameter int DATA_BITS     = 512,
  parameter int SLICE_MODE    = SLICE_MODE_FULL,
  parameter int HAS_KEEP_LAST = 1
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [DATA_BITS-1:0]   s_data,
  input  logic [DATA_BITS/8-1:0] s_keep,
  input  logic                   s_last,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [DATA_BITS-1:0]   m_data,
  output logic [DATA_BITS/8-1:0] m_keep,
  output logic                   m_last
);

  localparam int KEEP_BITS = DATA_BITS / 8;

  logic [KEEP_BITS-1:0] keep_out;
  logic                 last_out;

  // Without keep/last, every beat is a full single-beat packet downstream.
  assign m_keep = (HAS_KEEP_LAST != 0) ? keep_out : {KEEP_BITS{1'b1}};
  assign m_last = (HAS_KEEP_LAST != 0) ? last_out : 1'b1;

  if (SLICE_MODE == SLICE_MODE_LIGHT) begin : g_light
    logic                 valid_reg;
    logic [DATA_BITS-1:0] data_reg;
    logic [KEEP_BITS-1:0] keep_reg;
    logic                 last_reg;

    assign s_ready  = !valid_reg || m_ready;
    assign m_valid  = valid_reg;
    assign m_data   = data_reg;
    assign keep_out = keep_reg;
    assign last_out = last_reg;

    // Valid flag: reload whenever the register is free or being emptied.
    always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) valid_reg <= 1'b0;
      else if (s_ready) valid_reg <= s_valid;
    end

    // Payload capture on accept; payload is deliberately not reset.
    always_ff @(posedge aclk) begin
      if (s_ready && s_valid) begin
        data_reg <= s_data;
        keep_reg <= s_keep;
        last_reg <= s_last;
      end
    end
  end else begin : g_full
    logic                 main_valid_reg, skid_valid_reg;
    logic [DATA_BITS-1:0] main_data_reg, skid_data_reg;
    logic [KEEP_BITS-1:0] main_keep_reg, skid_keep_reg;
    logic                 main_last_reg, skid_last_reg;
    logic                 in_fire, load_main;

    // Ready comes straight from a flop, so no combinational path upstream.
    assign s_ready   = !skid_valid_reg;
    assign in_fire   = s_valid && !skid_valid_reg;
    assign load_main = !main_valid_reg || m_ready;
    assign m_valid   = main_valid_reg;
    assign m_data    = main_data_reg;
    assign keep_out  = main_keep_reg;
    assign last_out  = main_last_reg;

    // Valid flags: skid refills main first; a stalled arrival parks in skid.
    always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
        main_valid_reg <= 1'b0;
        skid_valid_reg <= 1'b0;
      end else if (load_main) begin
        main_valid_reg <= skid_valid_reg || in_fire;
        skid_valid_reg <= 1'b0;
      end else if (in_fire) begin
        skid_valid_reg <= 1'b1;
      end
    end

    // Payload moves alongside the valid flags; not reset.
    always_ff @(posedge aclk) begin
      if (load_main) begin
        if (skid_valid_reg) begin
          main_data_reg <= skid_data_reg;
          main_keep_reg <= skid_keep_reg;
          main_last_reg <= skid_last_reg;
        end else if (in_fire) begin
          main_data_reg <= s_data;
          main_keep_reg <= s_keep;
          main_last_reg <= s_last;
        end
      end else if (in_fire) begin
        skid_data_reg <= s_data;
        skid_keep_reg <= s_keep;
        skid_last_reg <= s_last;
      end
    end
  end

endmodule

// File: rtl/rdma_slice_chain_dcpl.sv
// Packet-aware decoupling gate feeding a parametrised chain of AXI4S slices,
// with occupancy tracking and idle/decoupled status.
module rdma_slice_chain_dcpl
  import lynxTypes::*;
#(
  parameter int DATA_BITS     = 512,
  parameter int N_STAGES      = 2,
  parameter int SLICE_MODE    = SLICE_MODE_FULL,
  parameter int HAS_KEEP_LAST = 1
) (
  input  logic                          aclk,
  input  logic                          aresetn,
  input  logic                          decouple,
  input  logic                          s_axis_tvalid,
  output logic                          s_axis_tready,
  input  logic [DATA_BITS-1:0]          s_axis_tdata,
  input  logic [DATA_BITS/8-1:0]        s_axis_tkeep,
  input  logic                          s_axis_tlast,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic [DATA_BITS-1:0]          m_axis_tdata,
  output logic [DATA_BITS/8-1:0]        m_axis_tkeep,
  output logic                          m_axis_tlast,
  output logic [occ_bits(N_STAGES)-1:0] occupancy,
  output logic                          idle,
  output logic                          decoupled
);

  localparam int KEEP_BITS = DATA_BITS / 8;
  localparam int OCC_BITS  = occ_bits(N_STAGES);

  logic                 run_reg, in_pkt_reg, gate_closed_reg;
  logic                 in_pkt_next, accept_en, in_fire;
  logic                 c_valid, c_ready, c_last;
  logic [KEEP_BITS-1:0] c_keep;

  // Input side only opens once out of reset and while the gate is open.
  assign accept_en     = run_reg && !gate_closed_reg;
  assign c_valid       = s_axis_tvalid && accept_en;
  assign c_keep        = (HAS_KEEP_LAST != 0) ? s_axis_tkeep : {KEEP_BITS{1'b1}};
  assign c_last        = (HAS_KEEP_LAST != 0) ? s_axis_tlast : 1'b1;
  assign s_axis_tready = c_ready && accept_en;
  assign in_fire       = s_axis_tvalid && s_axis_tready;

  // Packet tracking including this cycle's accept, so the gate never splits a packet.
  always_comb begin
    in_pkt_next = in_pkt_reg;
    if (HAS_KEEP_LAST == 0) in_pkt_next = 1'b0;
    else if (in_fire) in_pkt_next = !s_axis_tlast;
  end

  // Gate state: close only at a packet boundary, reopen as soon as decouple drops.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      run_reg         <= 1'b0;
      in_pkt_reg      <= 1'b0;
      gate_closed_reg <= 1'b0;
    end else begin
      run_reg         <= 1'b1;
      in_pkt_reg      <= in_pkt_next;
      gate_closed_reg <= decouple && !in_pkt_next;
    end
  end

  if (N_STAGES == 0) begin : g_wire
    assign m_axis_tvalid = c_valid;
    assign c_ready       = m_axis_tready;
    assign m_axis_tdata  = s_axis_tdata;
    assign m_axis_tkeep  = c_keep;
    assign m_axis_tlast  = c_last;
    assign occupancy     = '0;
  end else begin : g_chain
    for (genvar gi = 0; gi < N_STAGES; gi++) begin : g_st
      logic                 in_valid, in_ready, in_last;
      logic                 out_valid, out_ready, out_last;
      logic [DATA_BITS-1:0] in_data, out_data;
      logic [KEEP_BITS-1:0] in_keep, out_keep;

      if (gi == 0) begin : g_head
        assign in_valid = c_valid;
        assign in_data  = s_axis_tdata;
        assign in_keep  = c_keep;
        assign in_last  = c_last;
      end else begin : g_link
        assign in_valid = g_st[gi-1].out_valid;
        assign in_data  = g_st[gi-1].out_data;
        assign in_keep  = g_st[gi-1].out_keep;
        assign in_last  = g_st[gi-1].out_last;
      end

      if (gi == N_STAGES - 1) begin : g_tail
        assign out_ready = m_axis_tready;
      end else begin : g_fwd
        assign out_ready = g_st[gi+1].in_ready;
      end

      rdma_slice_stage #(
        .DATA_BITS    (DATA_BITS),
        .SLICE_MODE   (SLICE_MODE),
        .HAS_KEEP_LAST(HAS_KEEP_LAST)
      ) u_stage (
        .aclk   (aclk),
        .aresetn(aresetn),
        .s_valid(in_valid),
        .s_ready(in_ready),
        .s_data (in_data),
        .s_keep (in_keep),
        .s_last (in_last),
        .m_valid(out_valid),
        .m_ready(out_ready),
        .m_data (out_data),
        .m_keep (out_keep),
        .m_last (out_last)
      );
    end

    assign c_ready       = g_st[0].in_ready;
    assign m_axis_tvalid = g_st[N_STAGES-1].out_valid;
    assign m_axis_tdata  = g_st[N_STAGES-1].out_data;
    assign m_axis_tkeep  = g_st[N_STAGES-1].out_keep;
    assign m_axis_tlast  = g_st[N_STAGES-1].out_last;

    logic [OCC_BITS-1:0] occ_reg;
    logic                out_fire;

    assign out_fire  = m_axis_tvalid && m_axis_tready;
    assign occupancy = occ_reg;

    // Beats in flight: up on accept, down on delivery, steady when both happen.
    always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) occ_reg <= '0;
      else if (in_fire && !out_fire) occ_reg <= occ_reg + OCC_BITS'(1);
      else if (!in_fire && out_fire) occ_reg <= occ_reg - OCC_BITS'(1);
    end
  end

  assign idle      = (occupancy == '0);
  assign decoupled = gate_closed_reg && idle;

endmodule

// File: tb/tb_rdma_slice_chain_dcpl.sv
// Directed bench: FULL/2-stage chain with keep/last, plus a LIGHT/3-stage chain
// without keep/last, each checked through an in-order scoreboard.
module tb_rdma_slice_chain_dcpl;
  import lynxTypes::*;

  localparam int DW = 32;
  localparam int KW = DW / 8;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [KW-1:0] k;
    logic          l;
  } beat_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  // FULL, 2 stages, keep/last carried
  logic          a_dec, a_sv, a_sr, a_sl, a_mv, a_mr, a_ml, a_idle, a_dcp;
  logic [DW-1:0] a_sd, a_md;
  logic [KW-1:0] a_sk, a_mk;
  logic [occ_bits(2)-1:0] a_occ;
  // LIGHT, 3 stages, keep/last ignored
  logic          b_dec, b_sv, b_sr, b_sl, b_mv, b_mr, b_ml, b_idle, b_dcp;
  logic [DW-1:0] b_sd, b_md;
  logic [KW-1:0] b_sk, b_mk;
  logic [occ_bits(3)-1:0] b_occ;

  rdma_slice_chain_dcpl #(.DATA_BITS(DW), .N_STAGES(2), .SLICE_MODE(SLICE_MODE_FULL), .HAS_KEEP_LAST(1)) u_dut_a (
    .aclk(clk), .aresetn(rst_n), .decouple(a_dec),
    .s_axis_tvalid(a_sv), .s_axis_tready(a_sr), .s_axis_tdata(a_sd), .s_axis_tkeep(a_sk), .s_axis_tlast(a_sl),
    .m_axis_tvalid(a_mv), .m_axis_tready(a_mr), .m_axis_tdata(a_md), .m_axis_tkeep(a_mk), .m_axis_tlast(a_ml),
    .occupancy(a_occ), .idle(a_idle), .decoupled(a_dcp));

  rdma_slice_chain_dcpl #(.DATA_BITS(DW), .N_STAGES(3), .SLICE_MODE(SLICE_MODE_LIGHT), .HAS_KEEP_LAST(0)) u_dut_b (
    .aclk(clk), .aresetn(rst_n), .decouple(b_dec),
    .s_axis_tvalid(b_sv), .s_axis_tready(b_sr), .s_axis_tdata(b_sd), .s_axis_tkeep(b_sk), .s_axis_tlast(b_sl),
    .m_axis_tvalid(b_mv), .m_axis_tready(b_mr), .m_axis_tdata(b_md), .m_axis_tkeep(b_mk), .m_axis_tlast(b_ml),
    .occupancy(b_occ), .idle(b_idle), .decoupled(b_dcp));

  beat_t qa[$];
  beat_t qb[$];
  int checks = 0;
  int passes = 0;
  int unsigned cyc = 0;
  int unsigned a_in_n, a_out_n, a_first_in, a_first_out, a_last_out, a_occ_max;
  int unsigned b_out_n;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Scoreboard for chain A: push on input accept, pop and compare on output accept.
  always @(negedge clk) begin
    beat_t e;
    if (rst_n) begin
      if (a_sv && a_sr) begin
        qa.push_back('{d: a_sd, k: a_sk, l: a_sl});
        if (a_in_n == 0) a_first_in = cyc;
        a_in_n++;
      end
      if (a_mv && a_mr) begin
        check("a_sb_nonempty", 64'(qa.size() != 0), 64'd1);
        if (qa.size() != 0) begin
          e = qa.pop_front();
          check("a_tdata", 64'(a_md), 64'(e.d));
          check("a_tkeep", 64'(a_mk), 64'(e.k));
          check("a_tlast", 64'(a_ml), 64'(e.l));
          $display("A beat data=%08h keep=%h last=%0d cyc=%0d", a_md, a_mk, a_ml, cyc);
        end
        if (a_out_n == 0) a_first_out = cyc;
        a_last_out = cyc;
        a_out_n++;
      end
      if (32'(a_occ) > a_occ_max) a_occ_max = 32'(a_occ);
    end
  end

  // Scoreboard for chain B: without keep/last every beat leaves as keep=all-ones, last=1.
  always @(negedge clk) begin
    beat_t e;
    if (rst_n) begin
      if (b_sv && b_sr) qb.push_back('{d: b_sd, k: {KW{1'b1}}, l: 1'b1});
      if (b_mv && b_mr) begin
        check("b_sb_nonempty", 64'(qb.size() != 0), 64'd1);
        if (qb.size() != 0) begin
          e = qb.pop_front();
          check("b_tdata", 64'(b_md), 64'(e.d));
          check("b_tkeep", 64'(b_mk), 64'(e.k));
          check("b_tlast", 64'(b_ml), 64'(e.l));
        end
        b_out_n++;
      end
      check("b_occ_le3", 64'(b_occ <= 3), 64'd1);
      if (b_occ == 3 && !b_dec) check("b_ready_follows_mready", 64'(b_sr), 64'(b_mr));
    end
  end

  task automatic send_a(input logic [DW-1:0] d, input logic [KW-1:0] k, input logic l);
    bit ok = 0;
    a_sv = 1'b1; a_sd = d; a_sk = k; a_sl = l;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (a_sr) begin ok = 1; break; end
    end
    check("a_send_accept", 64'(ok), 64'd1);
    @(posedge clk); #1;
    a_sv = 1'b0;
  endtask

  task automatic drain_a();
    for (int c = 0; c < 500; c++) begin
      @(negedge clk);
      if (!a_mv && qa.size() == 0) break;
    end
    check("a_drain", 64'(qa.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  task automatic drain_b();
    for (int c = 0; c < 500; c++) begin
      @(negedge clk);
      if (!b_mv && qb.size() == 0) break;
    end
    check("b_drain", 64'(qb.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  task automatic clear_stats();
    a_in_n = 0; a_out_n = 0; a_first_in = 0; a_first_out = 0; a_last_out = 0; a_occ_max = 0;
  endtask

  initial begin
    int k;
    int cnt;
    bit acc;
    rst_n = 1'b0;
    a_dec = 0; a_sv = 0; a_sd = '0; a_sk = '0; a_sl = 0; a_mr = 0;
    b_dec = 0; b_sv = 0; b_sd = '0; b_sk = '0; b_sl = 0; b_mr = 0;
    b_out_n = 0;
    clear_stats();

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_a_mvalid", 64'(a_mv), 64'd0);
    check("rst_a_sready", 64'(a_sr), 64'd0);
    check("rst_a_occ", 64'(a_occ), 64'd0);
    check("rst_a_idle", 64'(a_idle), 64'd1);
    check("rst_a_decoupled", 64'(a_dcp), 64'd0);
    check("rst_b_sready", 64'(b_sr), 64'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check("a_ready_after_release", 64'(a_sr), 64'd1);

    // Back-to-back streaming: 2-cycle latency, 1 beat/cycle, occupancy peaks at 2
    a_mr = 1'b1;
    clear_stats();
    for (int i = 0; i < 100; i++) send_a(DW'(i), 4'hF, (i % 10) == 9);
    drain_a();
    check("p1_out_count", 64'(a_out_n), 64'd100);
    check("p1_latency", 64'(a_first_out - a_first_in), 64'd2);
    check("p1_throughput", 64'(a_last_out - a_first_out), 64'd99);
    check("p1_occ_peak", 64'(a_occ_max), 64'd2);

    // Output stalled: chain fills with exactly 4 beats then drains without bubbles
    a_mr = 1'b0;
    clear_stats();
    k = 0;
    a_sv = 1'b1; a_sd = '0; a_sk = 4'hA; a_sl = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (a_sr) k++;
      @(posedge clk); #1;
      a_sd = DW'(k);
    end
    a_sv = 1'b0;
    check("p2_accepted", 64'(k), 64'd4);
    check("p2_sready_full", 64'(a_sr), 64'd0);
    check("p2_occ_full", 64'(a_occ), 64'd4);
    a_mr = 1'b1;
    drain_a();
    check("p2_out_count", 64'(a_out_n), 64'd4);
    check("p2_no_bubbles", 64'(a_last_out - a_first_out), 64'd3);

    // Decouple mid-packet: rest of packet accepted, gate closes after tlast
    clear_stats();
    for (int i = 0; i < 8; i++) begin
      if (i == 3) a_dec = 1'b1;
      send_a(DW'(32'h100 + i), 4'(i), i == 7);
    end
    check("p4_gate_closed", 64'(a_sr), 64'd0);
    drain_a();
    check("p4_out_count", 64'(a_out_n), 64'd8);
    check("p4_decoupled", 64'(a_dcp), 64'd1);
    check("p4_idle", 64'(a_idle), 64'd1);
    k = 0;
    a_sv = 1'b1; a_sd = 32'hDEAD; a_sk = 4'hF; a_sl = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (a_sr) k++;
    end
    @(posedge clk); #1;
    a_sv = 1'b0;
    check("p4_no_accept_closed", 64'(k), 64'd0);

    // Reopen: ready the cycle after deassert, next packet intact
    a_dec = 1'b0;
    @(posedge clk); #1;
    check("p5_reopen", 64'(a_sr), 64'd1);
    check("p5_not_decoupled", 64'(a_dcp), 64'd0);
    for (int i = 0; i < 4; i++) send_a(DW'(32'h200 + i), 4'hC, i == 3);
    drain_a();
    check("p5_out_count", 64'(a_out_n), 64'd12);

    // Decouple at a packet boundary with a beat on the same cycle: beat wins, gate closes next
    a_dec = 1'b1;
    a_sv = 1'b1; a_sd = 32'h55; a_sk = 4'h0; a_sl = 1'b1;
    @(negedge clk);
    check("p5_same_cycle_accept", 64'(a_sr), 64'd1);
    @(posedge clk); #1;
    a_sv = 1'b0;
    check("p5_closed_next", 64'(a_sr), 64'd0);
    drain_a();
    a_dec = 1'b0;
    @(posedge clk); #1;

    // LIGHT chain, random valid/ready, 1000 beats
    cnt = 0;
    for (int c = 0; c < 20000; c++) begin
      @(negedge clk);
      acc = b_sv && b_sr;
      @(posedge clk); #1;
      if (acc) cnt++;
      if (cnt >= 1000) begin b_sv = 1'b0; break; end
      if (!b_sv || acc) begin
        b_sv = 1'($urandom_range(0, 1));
        b_sd = $urandom;
        b_sk = 4'($urandom);
        b_sl = 1'($urandom);
      end
      b_mr = 1'($urandom_range(0, 1));
    end
    b_sv = 1'b0;
    b_mr = 1'b1;
    drain_b();
    check("b_in_count", 64'(cnt), 64'd1000);
    check("b_out_count", 64'(b_out_n), 64'd1000);

    // Without keep/last the gate closes on the next cycle even though tlast=0
    b_dec = 1'b1;
    b_sv = 1'b1; b_sd = 32'hB0B0; b_sl = 1'b0;
    @(negedge clk);
    check("b_same_cycle_accept", 64'(b_sr), 64'd1);
    @(posedge clk); #1;
    b_sd = 32'hB0B1;
    check("b_gate_closed_no_tlast", 64'(b_sr), 64'd0);
    b_sv = 1'b0;
    drain_b();
    check("b_decoupled", 64'(b_dcp), 64'd1);
    b_dec = 1'b0;
    @(posedge clk); #1;
    check("b_reopen", 64'(b_sr), 64'd1);

    // Asynchronous reset mid-packet with 3 beats held
    a_mr = 1'b0;
    for (int i = 0; i < 3; i++) send_a(DW'(32'h300 + i), 4'hF, 1'b0);
    check("p6_occ_before", 64'(a_occ), 64'd3);
    #2;
    rst_n = 1'b0;
    #1;
    check("p6_rst_mvalid", 64'(a_mv), 64'd0);
    check("p6_rst_occ", 64'(a_occ), 64'd0);
    check("p6_rst_idle", 64'(a_idle), 64'd1);
    check("p6_rst_sready", 64'(a_sr), 64'd0);
    qa.delete();
    qb.delete();
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    clear_stats();
    a_mr = 1'b1;
    for (int i = 0; i < 3; i++) send_a(DW'(32'h400 + i), 4'h3, i == 2);
    drain_a();
    check("p6_out_count", 64'(a_out_n), 64'd3);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
